// File: rtl/bp_trig_gen.sv
// bp_trig_gen: transmit side of the bottle-print trigger interface.
// Debounces the electric eye, or uses an internal self-test ticker, and produces
// the arm/clear/trigger strobes plus road/cycle indices for the bottle-print block.
// Accepted triggers are followed by a hold-off window; events inside that window
// are counted as overruns instead of being emitted.
module bp_trig_gen #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int HOLDOFF_CYC  = 1000
) (
  input  logic        clk_100,
  input  logic        nRST,
  input  logic        run_en,
  input  logic        self_test,
  input  logic        eye_in,
  input  logic [15:0] test_period,
  input  logic [7:0]  road_max,
  input  logic [7:0]  cycle_max,
  output logic        dianyan_en,
  output logic        b_p_clr,
  output logic        valid_edge_f1,
  output logic [7:0]  b_p_road_num,
  output logic [7:0]  b_p_cycle_num,
  output logic        busy,
  output logic [7:0]  overrun_cnt
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int HO_W = $clog2(HOLDOFF_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYC - 1);

  typedef enum logic [1:0] {IDLE, CLR, ARM, HOLD} state_t;

  state_t          state;
  logic            run_en_d;
  logic [HO_W-1:0] hold_cnt;

  logic            eye_p0;
  logic            eye_p1;
  logic            db_lvl_p2;
  logic            db_lvl_p3;
  logic            eye_vld_p4;
  logic [DB_W-1:0] db_cnt;

  logic [15:0]     tick_cnt;
  logic            ticking;
  logic            tick;
  logic            evt;

  // Saturating overrun increment; the counter sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  // Next {cycle, road}; >= lets a live shrink of the limits wrap on the next bottle.
  function automatic logic [15:0] next_idx(input logic [7:0] road, input logic [7:0] cyc,
                                           input logic [7:0] rmax, input logic [7:0] cmax);
    logic [7:0] cyc_n;
    if (road >= rmax) begin
      cyc_n = (cyc >= cmax) ? 8'd0 : cyc + 8'd1;
      return {cyc_n, 8'd0};
    end
    return {cyc, road + 8'd1};
  endfunction

  // Eye path: 2-FF synchroniser (p0/p1), debounced level (p2), rising-edge event (p4).
  always_ff @(posedge clk_100) begin
    if (!nRST) begin
      eye_p0     <= 1'b0;
      eye_p1     <= 1'b0;
      db_lvl_p2  <= 1'b0;
      db_lvl_p3  <= 1'b0;
      eye_vld_p4 <= 1'b0;
      db_cnt     <= '0;
    end else begin
      eye_p0 <= eye_in;
      eye_p1 <= eye_p0;
      if (eye_p1 != db_lvl_p2) begin
        if (db_cnt == DB_LAST) begin
          db_lvl_p2 <= eye_p1;
          db_cnt    <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
      db_lvl_p3  <= db_lvl_p2;
      eye_vld_p4 <= db_lvl_p2 & ~db_lvl_p3;
    end
  end

  // Self-test ticker runs only while armed or holding off; test_period 0 disables ticks.
  always_comb begin
    ticking = self_test && ((state == ARM) || (state == HOLD));
    tick    = ticking && (test_period != 16'd0) && (tick_cnt >= test_period - 16'd1);
    evt     = self_test ? tick : eye_vld_p4;
  end

  // Ticker counter, restarted at every run start.
  always_ff @(posedge clk_100) begin
    if (!nRST) begin
      tick_cnt <= '0;
    end else if (state == CLR) begin
      tick_cnt <= '0;
    end else if (ticking) begin
      tick_cnt <= tick ? 16'd0 : tick_cnt + 16'd1;
    end
  end

  // Control FSM with registered strobes, indices and overrun counter.
  always_ff @(posedge clk_100) begin
    if (!nRST) begin
      state         <= IDLE;
      run_en_d      <= 1'b0;
      hold_cnt      <= '0;
      dianyan_en    <= 1'b0;
      b_p_clr       <= 1'b0;
      valid_edge_f1 <= 1'b0;
      b_p_road_num  <= 8'd0;
      b_p_cycle_num <= 8'd0;
      busy          <= 1'b0;
      overrun_cnt   <= 8'd0;
    end else begin
      run_en_d      <= run_en;
      valid_edge_f1 <= 1'b0;
      b_p_clr       <= 1'b0;
      if (valid_edge_f1) begin
        {b_p_cycle_num, b_p_road_num} <= next_idx(b_p_road_num, b_p_cycle_num,
                                                  road_max, cycle_max);
      end
      case (state)
        IDLE: begin
          if (run_en && !run_en_d) begin
            state         <= CLR;
            b_p_clr       <= 1'b1;
            busy          <= 1'b1;
            b_p_road_num  <= 8'd0;
            b_p_cycle_num <= 8'd0;
            overrun_cnt   <= 8'd0;
          end
        end
        CLR: begin
          if (!run_en) begin
            state      <= IDLE;
            dianyan_en <= 1'b0;
            busy       <= 1'b0;
          end else begin
            state         <= ARM;
            dianyan_en    <= 1'b1;
            b_p_road_num  <= 8'd0;
            b_p_cycle_num <= 8'd0;
            overrun_cnt   <= 8'd0;
          end
        end
        ARM: begin
          if (!run_en) begin
            state      <= IDLE;
            dianyan_en <= 1'b0;
            busy       <= 1'b0;
          end else if (evt) begin
            state         <= HOLD;
            valid_edge_f1 <= 1'b1;
            hold_cnt      <= '0;
          end
        end
        HOLD: begin
          if (!run_en) begin
            state      <= IDLE;
            dianyan_en <= 1'b0;
            busy       <= 1'b0;
          end else begin
            if (evt) begin
              overrun_cnt <= sat_inc8(overrun_cnt);
            end
            if (hold_cnt == HO_LAST) begin
              state <= ARM;
            end else begin
              hold_cnt <= hold_cnt + HO_W'(1);
            end
          end
        end
        default: begin
          state      <= IDLE;
          dianyan_en <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_trig_gen.sv
// Bench for bp_trig_gen: two instances share stimulus, one with a short hold-off
// (20 cycles) and one with the default 1000-cycle hold-off.
module tb_bp_trig_gen;

  localparam int DB = 16;

  logic        clk = 1'b0;
  logic        nRST, run_en, self_test, eye_in;
  logic [15:0] test_period;
  logic [7:0]  road_max, cycle_max;

  logic        dian, clr, vld, busy;
  logic [7:0]  road, cyc, ovr;
  logic        dian_h, clr_h, vld_h, busy_h;
  logic [7:0]  road_h, cyc_h, ovr_h;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] pair_q[$];
  int          exp_q[$];

  always #5 clk = ~clk;

  bp_trig_gen #(.DEBOUNCE_CYC(DB), .HOLDOFF_CYC(20)) dut (
    .clk_100(clk), .nRST(nRST), .run_en(run_en), .self_test(self_test), .eye_in(eye_in),
    .test_period(test_period), .road_max(road_max), .cycle_max(cycle_max),
    .dianyan_en(dian), .b_p_clr(clr), .valid_edge_f1(vld), .b_p_road_num(road),
    .b_p_cycle_num(cyc), .busy(busy), .overrun_cnt(ovr));

  bp_trig_gen #(.DEBOUNCE_CYC(DB), .HOLDOFF_CYC(1000)) dut_h (
    .clk_100(clk), .nRST(nRST), .run_en(run_en), .self_test(self_test), .eye_in(eye_in),
    .test_period(test_period), .road_max(road_max), .cycle_max(cycle_max),
    .dianyan_en(dian_h), .b_p_clr(clr_h), .valid_edge_f1(vld_h), .b_p_road_num(road_h),
    .b_p_cycle_num(cyc_h), .busy(busy_h), .overrun_cnt(ovr_h));

  task automatic step();
    @(negedge clk);
  endtask

  // Hold reset with the given configuration, then release at a falling edge.
  task automatic start_run(input logic st, input logic [15:0] per,
                           input logic [7:0] rmax, input logic [7:0] cmax);
    nRST = 1'b0; run_en = 1'b1; eye_in = 1'b0;
    self_test = st; test_period = per; road_max = rmax; cycle_max = cmax;
    step(); step();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; run_en = 1'b0; self_test = 1'b0; eye_in = 1'b0;
    test_period = 16'd0; road_max = 8'd0; cycle_max = 8'd0;
    repeat (3) step();
    n_tests++;
    if ({vld, clr, dian, busy, road, cyc, ovr} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h exp 0", {vld, clr, dian, busy, road, cyc, ovr});
    end
    n_tests++;
    if ({vld_h, clr_h, dian_h, busy_h, road_h, cyc_h, ovr_h} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_h got %h exp 0", {vld_h, clr_h, dian_h, busy_h, road_h, cyc_h, ovr_h});
    end
  endtask

  task automatic test_self_test();
    logic [15:0] ep;
    int clr_at, last, np, nclr, got, expd;
    logic prev_vld;
    pair_q = {};
    pair_q.push_back({8'd0, 8'd0}); pair_q.push_back({8'd1, 8'd0});
    pair_q.push_back({8'd2, 8'd0}); pair_q.push_back({8'd0, 8'd1});
    pair_q.push_back({8'd1, 8'd1}); pair_q.push_back({8'd2, 8'd1});
    pair_q.push_back({8'd0, 8'd0});
    start_run(1'b1, 16'd50, 8'd2, 8'd1);
    clr_at = 0; last = 0; np = 0; nclr = 0; prev_vld = 1'b0;
    for (int c = 1; c <= 500 && pair_q.size() > 0; c++) begin
      step();
      if (clr) begin nclr++; clr_at = c; end
      if (vld) begin
        n_tests++;
        if (clr) begin n_fail++; $display("FAIL st_clr_overlap got clr=1 exp 0"); end
        n_tests++;
        if (prev_vld) begin n_fail++; $display("FAIL st_back_to_back got prev_vld=1 exp 0"); end
        got  = (np == 0) ? c - clr_at : c - last;
        expd = (np == 0) ? 51 : 50;
        n_tests++;
        if (got !== expd) begin n_fail++; $display("FAIL st_interval[%0d] got %0d exp %0d", np, got, expd); end
        ep = pair_q.pop_front();
        n_tests++;
        if ({road, cyc} !== ep) begin
          n_fail++;
          $display("FAIL st_index[%0d] got (%0d,%0d) exp (%0d,%0d)", np, road, cyc, ep[15:8], ep[7:0]);
        end
        n_tests++;
        if (dian !== 1'b1) begin n_fail++; $display("FAIL st_dianyan got %b exp 1", dian); end
        last = c; np++;
      end
      prev_vld = vld;
    end
    n_tests++;
    if (pair_q.size() != 0) begin n_fail++; $display("FAIL st_timeout got %0d pulses exp 7", np); end
    n_tests++;
    if (nclr !== 1) begin n_fail++; $display("FAIL st_clr_count got %0d exp 1", nclr); end
  endtask

  task automatic test_road_zero();
    logic [15:0] ep;
    int last, np;
    pair_q = {};
    pair_q.push_back({8'd0, 8'd0}); pair_q.push_back({8'd0, 8'd1});
    pair_q.push_back({8'd0, 8'd2}); pair_q.push_back({8'd0, 8'd3});
    pair_q.push_back({8'd0, 8'd0});
    start_run(1'b1, 16'd50, 8'd0, 8'd3);
    last = 0; np = 0;
    for (int c = 1; c <= 400 && pair_q.size() > 0; c++) begin
      step();
      if (vld) begin
        if (np > 0) begin
          n_tests++;
          if (c - last !== 50) begin n_fail++; $display("FAIL rz_interval got %0d exp 50", c - last); end
        end
        ep = pair_q.pop_front();
        n_tests++;
        if ({road, cyc} !== ep) begin
          n_fail++;
          $display("FAIL rz_index[%0d] got (%0d,%0d) exp (%0d,%0d)", np, road, cyc, ep[15:8], ep[7:0]);
        end
        last = c; np++;
      end
    end
    n_tests++;
    if (pair_q.size() != 0) begin n_fail++; $display("FAIL rz_timeout got %0d pulses exp 5", np); end
  endtask

  task automatic test_eye();
    int np, e;
    start_run(1'b0, 16'd0, 8'd0, 8'd0);
    repeat (30) step();
    exp_q = {};
    // First sampling edge is the 1st rising edge; the pulse lands DB+3 edges later.
    exp_q.push_back(DB + 4);
    eye_in = 1'b1;
    np = 0;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (vld) begin
        np++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_tests++;
          if (c !== e) begin n_fail++; $display("FAIL eye_latency got %0d exp %0d", c, e); end
        end
      end
    end
    eye_in = 1'b0;
    n_tests++;
    if (np !== 1) begin n_fail++; $display("FAIL eye_pulse_count got %0d exp 1", np); end
    n_tests++;
    if (ovr !== 8'd0) begin n_fail++; $display("FAIL eye_overrun got %0d exp 0", ovr); end
  endtask

  task automatic test_glitch();
    int np;
    eye_in = 1'b0;
    repeat (40) step();
    eye_in = 1'b1;
    repeat (DB - 1) step();
    eye_in = 1'b0;
    np = 0;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (vld) np++;
    end
    n_tests++;
    if (np !== 0) begin n_fail++; $display("FAIL glitch_pulses got %0d exp 0", np); end
    n_tests++;
    if (ovr !== 8'd0) begin n_fail++; $display("FAIL glitch_overrun got %0d exp 0", ovr); end
    n_tests++;
    if (dian !== 1'b1) begin n_fail++; $display("FAIL glitch_armed got %b exp 1", dian); end
  endtask

  task automatic test_overrun();
    int last, np, e;
    logic prev_vld;
    exp_q = {};
    // 100 ticks of period 10 fall inside each 1000-cycle hold-off.
    exp_q.push_back(0); exp_q.push_back(100); exp_q.push_back(200);
    exp_q.push_back(255); exp_q.push_back(255);
    start_run(1'b1, 16'd10, 8'd0, 8'd0);
    last = 0; np = 0; prev_vld = 1'b0;
    for (int c = 1; c <= 5000 && exp_q.size() > 0; c++) begin
      step();
      if (vld_h) begin
        n_tests++;
        if (prev_vld) begin n_fail++; $display("FAIL ov_back_to_back got prev_vld=1 exp 0"); end
        n_tests++;
        if ((np == 0 ? c : c - last) !== (np == 0 ? 12 : 1010)) begin
          n_fail++;
          $display("FAIL ov_interval[%0d] got %0d exp %0d", np, np == 0 ? c : c - last, np == 0 ? 12 : 1010);
        end
        e = exp_q.pop_front();
        n_tests++;
        if (int'(ovr_h) !== e) begin n_fail++; $display("FAIL ov_count[%0d] got %0d exp %0d", np, ovr_h, e); end
        last = c; np++;
      end
      prev_vld = vld_h;
    end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL ov_timeout got %0d pulses exp 5", np); end
  endtask

  task automatic test_run_drop();
    int np;
    start_run(1'b1, 16'd50, 8'd2, 8'd1);
    np = 0;
    for (int c = 1; c <= 200 && np < 2; c++) begin
      step();
      if (vld) np++;
    end
    n_tests++;
    if (np !== 2) begin n_fail++; $display("FAIL rd_setup got %0d pulses exp 2", np); end
    // Land on the cycle in which the third tick fires, then drop run_en.
    repeat (49) step();
    run_en = 1'b0;
    step();
    n_tests++;
    if ({vld, dian, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL rd_idle got vld/dian/busy=%b exp 000", {vld, dian, busy});
    end
    n_tests++;
    if ({road, cyc, ovr} !== {8'd2, 8'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL rd_held got (%0d,%0d,%0d) exp (2,0,0)", road, cyc, ovr);
    end
    np = 0;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (vld || clr) np++;
    end
    n_tests++;
    if (np !== 0) begin n_fail++; $display("FAIL rd_quiet got %0d strobes exp 0", np); end
    run_en = 1'b1;
    step();
    n_tests++;
    if (clr !== 1'b1) begin n_fail++; $display("FAIL rd_clr got %b exp 1", clr); end
    step();
    n_tests++;
    if ({clr, dian, road, cyc} !== {1'b0, 1'b1, 8'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL rd_restart got clr=%b dian=%b road=%0d cyc=%0d exp 0 1 0 0", clr, dian, road, cyc);
    end
  endtask

  task automatic test_reset_hold();
    int np;
    start_run(1'b1, 16'd50, 8'd2, 8'd1);
    np = 0;
    for (int c = 1; c <= 100 && np < 1; c++) begin
      step();
      if (vld) np++;
    end
    n_tests++;
    if (np !== 1) begin n_fail++; $display("FAIL rh_setup got %0d pulses exp 1", np); end
    nRST = 1'b0;
    step();
    n_tests++;
    if ({vld, clr, dian, busy, road, cyc, ovr} !== 28'd0) begin
      n_fail++;
      $display("FAIL rh_outputs got %h exp 0", {vld, clr, dian, busy, road, cyc, ovr});
    end
  endtask

  initial begin
    nRST = 1'b0; run_en = 1'b0; self_test = 1'b0; eye_in = 1'b0;
    test_period = 16'd0; road_max = 8'd0; cycle_max = 8'd0;
    test_reset();
    test_self_test();
    test_road_zero();
    test_eye();
    test_glitch();
    test_overrun();
    test_run_drop();
    test_reset_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
